// File: rtl/button_pkg.sv
// Shared constants for the push-button input path.
// BTN_W is also used by the downstream edge/pause generator, so both stages
// agree on the button vector width.
package button_pkg;

    localparam int unsigned BTN_W                = 20;
    localparam int unsigned TICK_DIV_DEFAULT     = 50000;  // 1 ms at 50 MHz
    localparam int unsigned STABLE_TICKS_DEFAULT = 10;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-bit debouncer: 2-flop synchroniser, stability counter and the
// debounced output flop.
//
// Ports:
//   clk     - block clock
//   rst_n   - asynchronous active-low reset
//   tick    - sample strobe from the shared prescaler
//   raw     - raw pin level, already in pressed = 1 polarity
//   button  - debounced level
//   update  - combinational strobe, high in the cycle whose clock edge
//             loads a new value into button
module debounce_cell
    import button_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic button,
    output logic update
);

    localparam int unsigned    CNT_W   = clog2_min1(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    logic [1:0]       sync_q;
    logic             sync;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             button_q, button_d;

    assign sync = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            cnt_q    <= '0;
            button_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw};
            cnt_q    <= cnt_d;
            button_q <= button_d;
        end
    end

    // cnt holds the number of consecutive differing samples seen so far; the
    // STABLE_TICKS-th one commits the new level.
    always_comb begin
        cnt_d    = cnt_q;
        button_d = button_q;
        update   = 1'b0;
        if (tick) begin
            if (sync == button_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                button_d = sync;
                cnt_d    = '0;
                update   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign button = button_q;

endmodule

// File: rtl/button_debounce.sv
// Debounce stage for the board push-buttons. Synchronises and filters each
// raw pin and presents a level-stable, pressed = 1 button vector.
//
// Ports:
//   clk      - block clock
//   rst_n    - asynchronous active-low reset
//   btn_raw  - raw asynchronous pin levels (WIDTH)
//   button   - debounced levels, 1 = pressed (WIDTH)
//   changed  - one-cycle pulse aligned with any update of button
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned WIDTH        = BTN_W,
    parameter int unsigned TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] button,
    output logic             changed
);

    localparam int unsigned      DIV_W   = clog2_min1(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [WIDTH-1:0] raw_pressed;
    logic [WIDTH-1:0] update;
    logic             changed_q;

    // Shared sample prescaler; with TICK_DIV = 1 div stays 0 and tick is
    // permanently high.
    assign tick = (div_q == DIV_MAX);

    always_comb begin
        div_d = div_q + 1'b1;
        if (tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign raw_pressed = ACTIVE_LOW ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .raw    (raw_pressed[i]),
            .button (button[i]),
            .update (update[i])
        );
    end

    // Cell update strobes are combinational ahead of the button flops, so
    // registering their OR lines changed up with the new button value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |update;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;
    import button_pkg::*;

    localparam int unsigned W  = BTN_W;
    localparam int unsigned TD = 4;
    localparam int unsigned ST = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pressed = '0;
    logic [W-1:0] btn_raw;
    logic [W-1:0] button;
    logic         changed;

    assign btn_raw = ~pressed;  // pins are active-low

    button_debounce #(
        .WIDTH        (W),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .button  (button),
        .changed (changed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Window formulation: a bit takes a new level once the last ST tick
    // samples all disagree with its current level.
    typedef struct {
        int unsigned  edge_no;
        logic [W-1:0] level;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_win[$];
    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_pipe[2] = '{default: '0};
    int unsigned  m_edge = 0;
    logic [W-1:0] m_smp, m_next;
    bit           m_all;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_level = '0;
            m_pipe  = '{default: '0};
            m_win.delete();
            sb.delete();
            m_edge  = 0;
        end else begin
            m_edge++;
            m_smp     = m_pipe[1];       // pin value from two edges ago
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = pressed;
            if (m_edge % TD == 0) begin
                m_win.push_back(m_smp);
                if (m_win.size() > ST) void'(m_win.pop_front());
                m_next = m_level;
                if (m_win.size() == ST) begin
                    for (int b = 0; b < W; b++) begin
                        m_all = 1'b1;
                        for (int j = 0; j < ST; j++)
                            if (m_win[j][b] == m_level[b]) m_all = 1'b0;
                        if (m_all) m_next[b] = ~m_level[b];
                    end
                end
                if (m_next != m_level) begin
                    sb.push_back('{edge_no: m_edge, level: m_next});
                    m_level = m_next;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int   pulses = 0;
    exp_t got;

    initial forever begin
        @(negedge clk);
        if (changed === 1'b1) pulses++;
        if (!rst_n) begin
            check("reset_outputs", (button === '0) && (changed === 1'b0),
                  {changed, button}, 0);
        end else begin
            check("level", button === m_level, button, m_level);
            check("changed_vs_expected", changed === (sb.size() > 0), changed, sb.size() > 0);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                check("pulse_edge", got.edge_no == m_edge, m_edge, got.edge_no);
                check("pulse_level", button === got.level, button, got.level);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int unsigned p_edge, lat, p0, k;
    int unsigned hold, r;
    logic [W-1:0] flip;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_button(input int idx, input logic val);
        k = 0;
        while (button[idx] !== val && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("wait_bound", button[idx] === val, button[idx], val);
    endtask

    initial begin
        // Reset held with random pin activity.
        repeat (20) begin
            @(negedge clk);
            pressed = W'($urandom);
        end
        @(negedge clk);
        pressed = '0;
        rst_n   = 1'b1;
        cycles(30);

        // Clean press and release on bit 0.
        p0 = pulses;
        pressed[0] = 1'b1;
        p_edge = m_edge;
        wait_button(0, 1'b1);
        lat = m_edge - p_edge - 2;
        check("press_latency", lat >= 9 && lat <= 12, lat, 9);
        cycles(5);
        check("press_one_pulse", pulses - p0 == 1, pulses - p0, 1);
        p0 = pulses;
        pressed[0] = 1'b0;
        p_edge = m_edge;
        wait_button(0, 1'b0);
        lat = m_edge - p_edge - 2;
        check("release_latency", lat >= 9 && lat <= 12, lat, 9);
        cycles(5);
        check("release_one_pulse", pulses - p0 == 1, pulses - p0, 1);

        // Glitch of exactly two samples is rejected.
        p0 = pulses;
        pressed[5] = 1'b1;
        cycles(2 * TD);
        pressed[5] = 1'b0;
        cycles(40);
        check("glitch2_button", button[5] === 1'b0, button[5], 0);
        check("glitch2_pulses", pulses - p0 == 0, pulses - p0, 0);

        // Three samples are accepted, then released again.
        p0 = pulses;
        pressed[5] = 1'b1;
        cycles(3 * TD);
        pressed[5] = 1'b0;
        cycles(40);
        check("glitch3_pulses", pulses - p0 == 2, pulses - p0, 2);

        // Bounce every 3 cycles, then settle pressed.
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            pressed[7] = ~pressed[7];
            cycles(3);
        end
        pressed[7] = 1'b1;
        cycles(40);
        check("bounce_button", button[7] === 1'b1, button[7], 1);
        check("bounce_pulses", pulses - p0 == 1, pulses - p0, 1);
        pressed[7] = 1'b0;
        cycles(40);

        // Simultaneous change of bits 0 and 19.
        p0 = pulses;
        pressed[0]  = 1'b1;
        pressed[19] = 1'b1;
        cycles(40);
        check("simul_pulses", pulses - p0 == 1, pulses - p0, 1);
        check("simul_bits", button[0] && button[19], {button[19], button[0]}, 3);
        pressed[0]  = 1'b0;
        pressed[19] = 1'b0;
        cycles(40);

        // Staggered by one tick: two pulses.
        p0 = pulses;
        pressed[0] = 1'b1;
        cycles(TD);
        pressed[19] = 1'b1;
        cycles(40);
        check("stagger_pulses", pulses - p0 == 2, pulses - p0, 2);
        pressed[19] = 1'b0;
        cycles(40);

        // Reset mid-qualification on bit 3 while bit 0 is held high.
        pressed[3] = 1'b1;
        cycles(10);
        check("pre_reset_bit0", button[0] === 1'b1, button[0], 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", (button === '0) && (changed === 1'b0), {changed, button}, 0);
        cycles(2);
        rst_n = 1'b1;
        p0 = pulses;
        wait_button(3, 1'b1);
        check("requal_edge", m_edge == 3 * TD, m_edge, 3 * TD);
        cycles(5);
        check("requal_one_pulse", pulses - p0 == 1, pulses - p0, 1);
        pressed = '0;
        cycles(40);

        // Randomised activity with occasional bounce and resets.
        for (int s = 0; s < 250; s++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                @(posedge clk);
                #($urandom_range(1, 4));
                rst_n = 1'b0;
                cycles($urandom_range(1, 3));
                rst_n = 1'b1;
            end else if (r < 30) begin
                k = $urandom_range(0, W - 1);
                repeat ($urandom_range(2, 8)) begin
                    pressed[k] = ~pressed[k];
                    cycles($urandom_range(1, 5));
                end
            end else begin
                flip = W'($urandom) & W'($urandom) & W'($urandom);
                pressed = pressed ^ flip;
            end
            hold = $urandom_range(1, 30);
            cycles(hold);
        end

        cycles(60);
        check("scoreboard_drained", sb.size() == 0, sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
